uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8N1 serial transmitter. Supports a compile-time data width, plus a per-frame baud divisor, parity mode and stop-bit count. It uses a valid/ready input handshake, so frames can run back-to-back. It sits between the controller's debug/command path and the board UART pin.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first.
DIV_W, 16, width of runtime clocks-per-bit divisor.
FIFO_DEPTH, 16, input FIFO entries, power of 2 >= 2; used only when UART_TX_FIFO_EN is defined.

Ports:
i_Clock  in  1  single clock domain.
i_Reset  in  1  synchronous, active-high reset.
i_Tx_DV  in  1  input word valid.
o_Tx_Ready  out  1  block can accept a word; transfer occurs when i_Tx_DV & o_Tx_Ready at a rising edge.
i_Tx_Byte  in  DATA_BITS  word to send.
i_Clks_Per_Bit  in  DIV_W  clocks per bit (N); a value of 0 is treated as 1.
i_Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 none.
i_Two_Stop  in  1  0 = one stop bit, 1 = two stop bits.
o_Tx_Serial  out  1  serial line, idle high, registered.
o_Tx_Active  out  1  high while a frame is on the line.
o_Tx_Done  out  1  one-cycle pulse per completed frame.
o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; constant 0 without FIFO.

Behaviour:
- Reset (synchronous, active-high): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=0 while i_Reset=1, o_Fifo_Count=0, FIFO flushed, state IDLE.
- A frame aborted by reset emits no o_Tx_Done. The line is high at the first edge with reset asserted. Ready returns the cycle after reset release.
- Config latch: i_Clks_Per_Bit, i_Parity_Mode and i_Two_Stop are latched together with the data when a frame starts. Changes mid-frame do not affect the frame in flight.
- States and transitions:
  - IDLE -> START on a frame start.
  - START -> DATA.
  - DATA repeats for DATA_BITS bits.
  - DATA -> PARITY if parity is enabled, else DATA -> STOP.
  - PARITY -> STOP.
  - STOP lasts 1 or 2 bit periods, then -> IDLE with o_Tx_Done=1 for exactly that one cycle.
- Bit timing: every bit holds for exactly N clocks, using a DIV_W-bit counter that counts 0..N-1 and wraps.
- Parity: even = XOR of the data bits; odd = its inverse.
- Frame length in bits = 1 + DATA_BITS + (parity ? 1 : 0) + (two stop ? 2 : 1).
- Timing: a word accepted at edge k drives the start bit from edge k+1. o_Tx_Active is high from k+1 through the end of the last stop bit. o_Tx_Done pulses at k+1+bits*N.
- Without FIFO: o_Tx_Ready = (state==IDLE) & ~i_Reset. A word offered during the Done cycle starts on the next edge, giving a minimum inter-frame gap of 1 idle-high cycle.
- o_Tx_Done and acceptance of the next word in the same cycle is legal.

Optional Feature:
UART_TX_FIFO_EN:
- Defined:
  - FIFO_DEPTH-entry FIFO in front of the FSM.
  - o_Tx_Ready = ~full.
  - The FSM pops in IDLE when the FIFO is non-empty; the start bit begins the cycle after the pop, so the gap between frames is 1 cycle.
  - Simultaneous push and pop when full is not accepted (Ready=0). When empty, push and pop in the same cycle are not bypassed: the word pops the next cycle.
  - Per-frame config is sampled at push time and stored with each entry.
  - o_Fifo_Count reports occupancy from 0 to FIFO_DEPTH.
- Undefined: no FIFO storage, o_Fifo_Count tied to 0, Ready as in Behaviour.

Test Plan:
- Reset, N=5, mode 00, one stop, send 0x55 -> line 0,1,0,1,0,1,0,1,0,1, each held 5 clocks. Active high for 50 cycles; Done pulses once at k+51.
- Even parity, send 0x07 -> parity bit 1, 11-bit frame, Done at k+56. Odd parity, send 0x07 -> parity bit 0.
- N=3, two stop, send 0xFF -> line high 30 clocks after the 3-clock start bit. Done at k+34.
- Change i_Clks_Per_Bit 5->10 at data bit 2 -> current frame stays at 5 clocks per bit; next frame uses 10.
- Assert reset during data bit 3 -> line=1 and Active=0 at that edge, no Done. Ready=1 one cycle after release; the next 0xA5 frame is correct.
- FIFO_EN, FIFO_DEPTH=16, hold DV high with 20 sequential words -> Ready drops with count=16. All 20 frames emerge in order with a 1-cycle gap; count returns to 0.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data, per-frame divisor/parity/stop count, valid/ready input.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry word FIFO (with per-entry config) in front of the FSM.
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  output logic                          o_Tx_Ready,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  input  logic [DIV_W-1:0]              i_Clks_Per_Bit,
  input  logic [1:0]                    i_Parity_Mode,
  input  logic                          i_Two_Stop,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       nm1_q, nm1_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   par_en_q, par_en_d;
  logic                   par_q, par_d;
  logic                   two_q, two_d;
  logic                   stop2_q, stop2_d;
  logic                   fin_q, fin_d;
  logic                   serial_q, serial_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  logic                   start_frame;
  logic [DATA_BITS-1:0]   frm_data;
  logic [DIV_W-1:0]       frm_div;
  logic [1:0]             frm_mode;
  logic                   frm_two;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_BITS + DIV_W + 3;

  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  count;
  logic           full, empty, push, pop;

  assign count      = wr_q - rd_q;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign o_Tx_Ready = ~full & ~i_Reset;
  assign push       = i_Tx_DV & o_Tx_Ready;
  // Pop uses the registered empty flag, so a word pushed into an empty FIFO pops one cycle later.
  assign pop        = (state_q == S_IDLE) & ~empty & ~i_Reset;
  assign start_frame = pop;
  assign {frm_two, frm_mode, frm_div, frm_data} = mem_q[rd_q[AW-1:0]];
  assign o_Fifo_Count = count;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {i_Two_Stop, i_Parity_Mode, i_Clks_Per_Bit, i_Tx_Byte};
  end
`else
  assign o_Tx_Ready   = (state_q == S_IDLE) & ~i_Reset;
  assign start_frame  = i_Tx_DV & o_Tx_Ready;
  assign frm_data     = i_Tx_Byte;
  assign frm_div      = i_Clks_Per_Bit;
  assign frm_mode     = i_Parity_Mode;
  assign frm_two      = i_Two_Stop;
  assign o_Fifo_Count = '0;
`endif

  assign bit_end = (cnt_q == nm1_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nm1_d    = nm1_q;
    bit_d    = bit_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    two_d    = two_q;
    stop2_d  = stop2_q;
    fin_d    = 1'b0;
    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          state_d  = S_START;
          cnt_d    = '0;
          nm1_d    = (frm_div == '0) ? '0 : frm_div - 1'b1;
          bit_d    = '0;
          data_d   = frm_data;
          par_en_d = (frm_mode == 2'b01) | (frm_mode == 2'b10);
          par_d    = (^frm_data) ^ (frm_mode == 2'b10);
          two_d    = frm_two;
          stop2_d  = 1'b0;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) state_d = par_en_q ? S_PARITY : S_STOP;
          else                             bit_d   = bit_q + 1'b1;
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (two_q & ~stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM by one cycle:
  // the start bit appears the edge after acceptance and Done follows the return to IDLE.
  always_comb begin
    case (state_q)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = data_q[bit_q];
      S_PARITY: serial_d = par_q;
      default:  serial_d = 1'b1;
    endcase
    active_d = (state_q != S_IDLE);
    done_d   = fin_q;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      nm1_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      two_q    <= 1'b0;
      stop2_q  <= 1'b0;
      fin_q    <= 1'b0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nm1_q    <= nm1_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      two_q    <= two_d;
      stop2_q  <= stop2_d;
      fin_q    <= fin_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: driver queues expected frames, a monitor checks the serial line.
module tb_uart_tx_cfg;
  localparam int unsigned DB = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned FD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          dv;
  logic          rdy;
  logic [DB-1:0] tx_byte;
  logic [DW-1:0] cpb;
  logic [1:0]    pm;
  logic          ts;
  logic          ser;
  logic          act;
  logic          done;
  logic [$clog2(FD):0] fcnt;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(DB), .DIV_W(DW), .FIFO_DEPTH(FD)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Tx_DV        (dv),
    .o_Tx_Ready     (rdy),
    .i_Tx_Byte      (tx_byte),
    .i_Clks_Per_Bit (cpb),
    .i_Parity_Mode  (pm),
    .i_Two_Stop     (ts),
    .o_Tx_Serial    (ser),
    .o_Tx_Active    (act),
    .o_Tx_Done      (done),
    .o_Fifo_Count   (fcnt)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DB-1:0] data;
    int unsigned   n;
    logic [1:0]    mode;
    logic          par;
    int unsigned   bits;
    int unsigned   start;
    int unsigned   done_at;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned last_done = 0;
  bit          mon_quiet = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Caller is at a negedge. bits/par are the hand-computed frame length and parity bit.
  task automatic send(input logic [DB-1:0] d, input logic [DW-1:0] div, input logic [1:0] mode,
                      input logic two, input int unsigned bits, input logic par, input bit expect_frame);
    int unsigned k, n, p, w;
    exp_t e;
    tx_byte = d; cpb = div; pm = mode; ts = two; dv = 1'b1;
    w = 0;
    while (rdy !== 1'b1) begin
      @(negedge clk);
      w++;
      if (w > 3000) begin
        chk("ready_timeout", 32'd0, 32'd1);
        dv = 1'b0;
        return;
      end
    end
    k = cyc + 1;
    n = (div == 0) ? 1 : int'(div);
`ifdef UART_TX_FIFO_EN
    p = (k + 1 > last_done) ? k + 1 : last_done;
`else
    p = k;
`endif
    if (expect_frame) begin
      e.data = d; e.n = n; e.mode = mode; e.par = par; e.bits = bits;
      e.start = p + 1;
      e.done_at = p + 1 + bits * n;
      exp_q.push_back(e);
      last_done = e.done_at;
    end
    @(posedge clk);
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned b;
    b = 0;
    while ((exp_q.size() > 0 || cyc <= last_done + 1) && b < 20000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 20000) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  exp_t        me;
  logic [15:0] fr;
  logic        got;
  bit          bad, abad;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && cyc == exp_q[0].start) begin
        me = exp_q.pop_front();
        fr = '1;
        fr[0] = 1'b0;
        for (int unsigned i = 0; i < DB; i++) fr[1 + i] = me.data[i];
        if (me.mode == 2'b01 || me.mode == 2'b10) fr[1 + DB] = me.par;
        abad = 1'b0;
        for (int unsigned b = 0; b < me.bits; b++) begin
          bad = 1'b0;
          got = fr[b];
          for (int unsigned j = 0; j < me.n; j++) begin
            if (ser !== fr[b] && !bad) begin bad = 1'b1; got = ser; end
            if (act !== 1'b1) abad = 1'b1;
            if (done !== 1'b0) abad = 1'b1;
            @(negedge clk);
          end
          chk($sformatf("frame_%0h_bit%0d", me.data, b), got, fr[b]);
        end
        chk($sformatf("frame_%0h_active_no_early_done", me.data), abad, 1'b0);
        chk($sformatf("frame_%0h_done_pulse", me.data), done, 1'b1);
        chk($sformatf("frame_%0h_active_end", me.data), act, 1'b0);
        chk($sformatf("frame_%0h_line_idle", me.data), ser, 1'b1);
      end else if (!mon_quiet) begin
        if (done !== 1'b0) chk("spurious_done", done, 1'b0);
        if (ser !== 1'b1) chk("idle_line_high", ser, 1'b1);
      end
    end
  end

  initial begin
    bit seen;
    rst = 1'b1; dv = 1'b0; tx_byte = '0; cpb = 16'd5; pm = 2'b00; ts = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_serial", ser, 1'b1);
    chk("rst_active", act, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", rdy, 1'b0);
    chk("rst_fifo_count", fcnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", rdy, 1'b1);
    mon_quiet = 1'b0;

    send(8'h55, 16'd5, 2'b00, 1'b0, 10, 1'b0, 1'b1);
    send(8'h07, 16'd5, 2'b01, 1'b0, 11, 1'b1, 1'b1);
    send(8'h07, 16'd5, 2'b10, 1'b0, 11, 1'b0, 1'b1);
    send(8'hFF, 16'd3, 2'b00, 1'b1, 11, 1'b0, 1'b1);
    send(8'h3C, 16'd1, 2'b11, 1'b0, 10, 1'b0, 1'b1);
    send(8'h81, 16'd0, 2'b01, 1'b1, 12, 1'b0, 1'b1);
    wait_idle();

    // Divisor change during data bit 2 of an in-flight frame.
    send(8'h96, 16'd5, 2'b00, 1'b0, 10, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    cpb = 16'd10;
    send(8'h69, 16'd10, 2'b00, 1'b0, 10, 1'b0, 1'b1);
    wait_idle();

    // Reset in the middle of data bit 3.
    mon_quiet = 1'b1;
    send(8'hC3, 16'd5, 2'b00, 1'b0, 10, 1'b0, 1'b0);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_line_high", ser, 1'b1);
    chk("abort_active_low", act, 1'b0);
    chk("abort_ready_low", rdy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", rdy, 1'b1);
    seen = 1'b0;
    for (int unsigned i = 0; i < 60; i++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 1'b0);
    last_done = 0;
    mon_quiet = 1'b0;
    send(8'hA5, 16'd5, 2'b01, 1'b0, 11, 1'b0, 1'b1);
    wait_idle();

`ifdef UART_TX_FIFO_EN
    seen = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (rdy !== 1'b1 && !seen) begin
        chk("fifo_full_count", fcnt, FD);
        seen = 1'b1;
      end
      send(8'(i * 37 + 5), 16'd2, 2'b00, 1'b0, 10, 1'b0, 1'b1);
    end
    chk("fifo_went_full", seen, 1'b1);
    wait_idle();
`endif
    chk("fifo_count_end", fcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
